// File: rtl/equiv_bist_checker.sv
// equiv_bist_checker
// Built-in equivalence checker: drives a shared stimulus to a reference
// model (golden) and an implementation (netlist), compares their responses
// after each vector has settled, and reports a saturating mismatch count.
// Sequence: IDLE -> RST_PH (models held in reset) -> RUN (NUM_VEC LFSR
// vectors) -> DONE.
// Optional feature macro: CHK_FIRST_FAIL_CAPTURE_EN adds first-failure
// capture outputs (ff_valid, ff_index, ff_golden, ff_netlist).
module equiv_bist_checker #(
    parameter int          NUM_VEC = 1000,
    parameter int          SETTLE  = 2,
    parameter logic [31:0] SEED    = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] golden,
    input  logic [31:0] netlist,
    output logic [31:0] stim,
    output logic        dut_rst,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] vec_cnt
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
    ,
    output logic        ff_valid,
    output logic [15:0] ff_index,
    output logic [31:0] ff_golden,
    output logic [31:0] ff_netlist
`endif
);

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [15:0] VEC_LAST    = 16'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RST_PH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [3:0]  settle_cnt;

    logic [31:0] lfsr_nxt;
    logic        settle_end;
    logic        miscmp;
    logic        cmp_en;
    logic        restart;
    logic [15:0] mism_upd;

    // Galois LFSR step: shift right, fold the polynomial in when bit 0 was set.
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Saturating increment so the failure count never wraps back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Compare strobes and next-value helpers shared by the state registers.
    always_comb begin
        lfsr_nxt   = lfsr_adv(lfsr);
        settle_end = (settle_cnt == SETTLE_LAST);
        miscmp     = (golden != netlist);
        cmp_en     = ((state == RST_PH) || (state == RUN)) && settle_end;
        restart    = ((state == IDLE) || (state == DONE)) && start;
        mism_upd   = miscmp ? sat_inc(mismatch_cnt) : mismatch_cnt;
    end

    // Sequencer FSM with registered stimulus, model reset and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lfsr         <= SEED_EFF;
            settle_cnt   <= 4'd0;
            stim         <= 32'h0;
            dut_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= 16'h0;
            vec_cnt      <= 16'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RST_PH;
                        lfsr         <= SEED_EFF;
                        settle_cnt   <= 4'd0;
                        stim         <= 32'h0;
                        dut_rst      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        mismatch_cnt <= 16'h0;
                        vec_cnt      <= 16'h0;
                    end
                end
                RST_PH: begin
                    if (settle_end) begin
                        // Reset-phase compare counts failures but is not a vector.
                        settle_cnt   <= 4'd0;
                        mismatch_cnt <= mism_upd;
                        lfsr         <= lfsr_nxt;
                        stim         <= lfsr_nxt;
                        dut_rst      <= 1'b0;
                        state        <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                RUN: begin
                    if (settle_end) begin
                        settle_cnt   <= 4'd0;
                        mismatch_cnt <= mism_upd;
                        vec_cnt      <= vec_cnt + 16'd1;
                        if (vec_cnt == VEC_LAST) begin
                            // Final compare: stim and dut_rst freeze in DONE.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (mism_upd == 16'h0);
                        end else begin
                            lfsr <= lfsr_nxt;
                            stim <= lfsr_nxt;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CHK_FIRST_FAIL_CAPTURE_EN
    // Latch index and both responses of the first failing compare of a test.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_valid   <= 1'b0;
            ff_index   <= 16'h0;
            ff_golden  <= 32'h0;
            ff_netlist <= 32'h0;
        end else if (restart) begin
            ff_valid   <= 1'b0;
            ff_index   <= 16'h0;
            ff_golden  <= 32'h0;
            ff_netlist <= 32'h0;
        end else if (cmp_en && miscmp && !ff_valid) begin
            ff_valid   <= 1'b1;
            ff_index   <= (state == RUN) ? vec_cnt : 16'h0;
            ff_golden  <= golden;
            ff_netlist <= netlist;
        end
    end
`endif

endmodule

// File: tb/tb_equiv_bist_checker.sv
// tb_equiv_bist_checker
// Scoreboard bench: the stimulus side pushes expected run results and the
// expected stimulus sequence; monitors pop and compare when the checker
// changes stim or raises done. A second instance exercises count saturation.
module tb_equiv_bist_checker;

    localparam int          NV     = 1000;
    localparam int          ST     = 2;
    localparam logic [31:0] SEED_M = 32'h0;
    localparam int          NV_S   = 65535;
    localparam logic [31:0] SEED_S = 32'hDEAD_BEEF;

    typedef struct {
        int          start_cyc;
        int          latency;
        logic [15:0] mism;
        logic [15:0] vec;
        logic        pass;
        logic        ffv;
        logic [15:0] ffi;
        logic [31:0] ffg;
        logic [31:0] ffn;
    } exp_t;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } stim_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    exp_t  exp_q[$];
    exp_t  exp_s_q[$];
    stim_t stim_q[$];
    logic [31:0] exp_v [NV];
    logic        inj      = 1'b0;
    logic [31:0] inj_stim = 32'h0;
    bit          cur_nz   = 1'b0;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] golden, netlist, stim;
    logic        dut_rst, busy, done, pass;
    logic [15:0] mismatch_cnt, vec_cnt;
    logic        rst_s, start_s;
    logic [31:0] golden_s, netlist_s, stim_s;
    logic        dut_rst_s, busy_s, done_s, pass_s;
    logic [15:0] mismatch_cnt_s, vec_cnt_s;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
    logic        ff_valid, ff_valid_s;
    logic [15:0] ff_index, ff_index_s;
    logic [31:0] ff_golden, ff_golden_s, ff_netlist, ff_netlist_s;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Toy reference model: held at 0 while in reset.
    function automatic logic [31:0] gold_fn(input logic [31:0] s, input logic r);
        return r ? 32'h0 : ({s[7:0], s[31:8]} ^ 32'h5A5A_0F0F);
    endfunction

    // Spec-level LFSR step: shift right; if the bit shifted out was 1, XOR poly.
    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic lsb;
        lsb = s[0];
        s   = s >> 1;
        if (lsb) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    assign golden    = gold_fn(stim, dut_rst);
    assign netlist   = golden ^ ((inj && !dut_rst && (stim == inj_stim)) ? 32'h1 : 32'h0);
    assign golden_s  = stim_s;
    assign netlist_s = ~stim_s;

    equiv_bist_checker #(.NUM_VEC(NV), .SETTLE(ST), .SEED(SEED_M)) dut (
        .clk(clk), .rst(rst), .start(start), .golden(golden), .netlist(netlist),
        .stim(stim), .dut_rst(dut_rst), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .vec_cnt(vec_cnt)
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
        , .ff_valid(ff_valid), .ff_index(ff_index), .ff_golden(ff_golden), .ff_netlist(ff_netlist)
`endif
    );

    equiv_bist_checker #(.NUM_VEC(NV_S), .SETTLE(1), .SEED(SEED_S)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .golden(golden_s), .netlist(netlist_s),
        .stim(stim_s), .dut_rst(dut_rst_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .mismatch_cnt(mismatch_cnt_s), .vec_cnt(vec_cnt_s)
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
        , .ff_valid(ff_valid_s), .ff_index(ff_index_s), .ff_golden(ff_golden_s), .ff_netlist(ff_netlist_s)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic compare_rec(input string tag, input exp_t e, input logic [15:0] m,
                               input logic [15:0] v, input logic p);
        chk({tag, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.latency));
        chk({tag, "_mismatch_cnt"}, 32'(m), 32'(e.mism));
        chk({tag, "_vec_cnt"}, 32'(v), 32'(e.vec));
        chk({tag, "_pass"}, 32'(p), 32'(e.pass));
    endtask

    // Monitor: on each rising done, pop the expected result of that run.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, required no completion (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                compare_rec("run", e, mismatch_cnt, vec_cnt, pass);
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
                chk("ff_valid", 32'(ff_valid), 32'(e.ffv));
                if (e.ffv) begin
                    chk("ff_index", 32'(ff_index), 32'(e.ffi));
                    chk("ff_golden", ff_golden, e.ffg);
                    chk("ff_netlist", ff_netlist, e.ffn);
                end
`endif
            end
        end
        done_prev = done;
    end

    // Monitor: every change of stim must be the next expected value, on time.
    logic [31:0] stim_prev = 32'h0;
    always @(negedge clk) begin
        stim_t s;
        if (stim !== stim_prev) begin
            if (stim_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stim_unexpected: got %h, required no change (cycle %0d)", stim, cyc);
            end else begin
                s = stim_q.pop_front();
                chk("stim_value", stim, s.val);
                if (s.cyc >= 0) chk("stim_cycle", 32'(cyc), 32'(s.cyc));
            end
        end
        stim_prev = stim;
    end

    // Monitor for the saturation instance.
    logic done_s_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done_s && !done_s_prev) begin
            if (exp_s_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done_sat: got done=1, required no completion (cycle %0d)", cyc);
            end else begin
                e = exp_s_q.pop_front();
                compare_rec("sat", e, mismatch_cnt_s, vec_cnt_s, pass_s);
            end
        end
        done_s_prev = done_s;
    end

    // Issue a start pulse and push the model's expectations for the run.
    task automatic kick(output int sc);
        exp_t  e;
        stim_t s;
        int    nfail;
        int    first;
        nfail = 0;
        first = -1;
        for (int k = 0; k < NV; k++) begin
            if (inj && (exp_v[k] == inj_stim)) begin
                if (first < 0) first = k;
                nfail++;
            end
        end
        @(negedge clk);
        sc = cyc + 1;
        if (cur_nz) begin
            s.val = 32'h0;
            s.cyc = sc;
            stim_q.push_back(s);
        end
        for (int k = 0; k < NV; k++) begin
            s.val = exp_v[k];
            s.cyc = sc + ST * (k + 1);
            stim_q.push_back(s);
        end
        e.start_cyc = sc;
        e.latency   = ST * (NV + 1);
        e.mism      = 16'(nfail);
        e.vec       = 16'(NV);
        e.pass      = (nfail == 0);
        e.ffv       = (nfail != 0);
        e.ffi       = (first < 0) ? 16'h0 : 16'(first);
        e.ffg       = (first < 0) ? 32'h0 : gold_fn(exp_v[first], 1'b0);
        e.ffn       = e.ffg ^ 32'h1;
        exp_q.push_back(e);
        cur_nz = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * ST * (NV + 1)) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_at(input int t);
        while (cyc < t) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic main_seq();
        int sc;
        int n;
        // Reset state while rst is held low.
        repeat (2) @(negedge clk);
        chk("rst_stim", stim, 32'h0);
        chk("rst_dut_rst", 32'(dut_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Run A: responses agree; reset phase and first RUN vector timing.
        kick(sc);
        chk("rstph_busy", 32'(busy), 32'd1);
        chk("rstph_dut_rst", 32'(dut_rst), 32'd1);
        while (cyc < sc + ST) @(negedge clk);
        chk("first_run_stim", stim, 32'h8020_0003);
        chk("first_run_dut_rst", 32'(dut_rst), 32'd0);
        wait_drain("runA_done_budget");

        // Run B: single-bit fault on vector index 5, restarted from DONE.
        inj      = 1'b1;
        inj_stim = exp_v[5];
        kick(sc);
        wait_drain("runB_done_budget");
        inj      = 1'b0;

        // Run C: asynchronous reset mid-RUN, then a clean rerun.
        kick(sc);
        n = 0;
        while (vec_cnt != 16'd300 && n < 4 * ST * NV) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_300", 32'(vec_cnt), 32'd300);
        #2;
        exp_q.delete();
        stim_q.delete();
        stim_q.push_back('{val: 32'h0, cyc: -1});
        rst = 1'b0;
        #1;
        chk("abort_stim", stim, 32'h0);
        chk("abort_dut_rst", 32'(dut_rst), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        chk("abort_vec_cnt", 32'(vec_cnt), 32'd0);
        cur_nz = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_dut_rst", 32'(dut_rst), 32'd1);
        kick(sc);
        wait_drain("runC_done_budget");

        // Run D: start pulses while busy and in the final-compare cycle.
        kick(sc);
        pulse_at(sc + 1);
        pulse_at(sc + 4 + int'($urandom_range(0, ST * NV - 20)));
        pulse_at(sc + ST * (NV + 1) - 1);
        wait_drain("runD_done_budget");
        repeat (3) @(negedge clk);
        chk("runD_done_held", 32'(done), 32'd1);
        chk("runD_busy", 32'(busy), 32'd0);
        chk("runD_vec_cnt", 32'(vec_cnt), 32'(NV));
        chk("runD_stim_held", stim, exp_v[NV-1]);
    endtask

    task automatic sat_seq();
        exp_t e;
        int   n;
        repeat (2) @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        e.start_cyc = cyc + 1;
        e.latency   = 1 * (NV_S + 1);
        e.mism      = 16'hFFFF;
        e.vec       = 16'(NV_S);
        e.pass      = 1'b0;
        e.ffv       = 1'b1;
        e.ffi       = 16'h0;
        e.ffg       = 32'h0;
        e.ffn       = 32'hFFFF_FFFF;
        exp_s_q.push_back(e);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (exp_s_q.size() != 0 && n < NV_S + 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_done_budget", 32'(exp_s_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] s;
        rst     = 1'b1;
        rst_s   = 1'b1;
        start   = 1'b0;
        start_s = 1'b0;
        #1;
        rst     = 1'b0;
        rst_s   = 1'b0;
        s = (SEED_M == 32'h0) ? 32'h1 : SEED_M;
        for (int k = 0; k < NV; k++) begin
            s = model_step(s);
            exp_v[k] = s;
        end
        fork
            main_seq();
            sat_seq();
        join
        chk("sb_main_drained", 32'(exp_q.size()), 32'd0);
        chk("sb_stim_drained", 32'(stim_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
